btb_update_ctrl: RTL and testbench
==================================

# btb_update_ctrl

Sequencing controller for the 16-entry, 16-bit Branch Target Buffer. It accepts target updates resolved in the decode stage and buffers them in a small FIFO. It issues them to the BTB write port one per cycle and keeps a per-entry valid-bit array that qualifies fetch-stage predictions. It also runs a 16-cycle zeroing sweep of the BTB on a flush request (context switch, self-modifying-code fence).

## Interface

Parameters:
- DEPTH, default 2, update FIFO depth. Power of two, ≥2.

Ports:
- clk  in  1  system clock; everything is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_index  in  4  lower 4 bits of the current fetch PC (BTB read index).
- pred_hit  out  1  combinational: valid[fetch_index].
- upd_valid  in  1  decode-stage update request.
- upd_ready  out  1  controller can accept an update this cycle.
- upd_index  in  4  lower 4 bits of the branch's PC.
- upd_target  in  16  resolved branch target.
- upd_taken  in  1  1 = install/refresh entry; 0 = invalidate entry.
- flush_req  in  1  single-cycle flush request.
- flush_busy  out  1  high while the sweep is running.
- btb_wen  out  1  BTB write enable (drives the BTB's write decoder).
- btb_windex  out  4  BTB write index.
- btb_wdata  out  16  BTB write data.

## Operation

- State machine has two states:
  - IDLE.
  - FLUSH, with a 4-bit sweep counter cnt.
- Update handshake:
  - An update is accepted on a rising edge where upd_valid & upd_ready.
  - An accepted update is pushed into the FIFO as {index, target, taken}.
  - upd_ready = !fifo_full.
  - Push is refused when the FIFO is full, even if a pop happens in the same cycle.
- IDLE, FIFO non-empty: the head is issued and popped every cycle.
  - Head taken=1: btb_wen=1, btb_windex=head.index, btb_wdata=head.target. valid[head.index] is set at that edge.
  - Head taken=0: btb_wen=0. valid[head.index] is cleared at that edge.
- IDLE, FIFO empty: btb_wen=0, btb_windex=0, btb_wdata=0.
- flush_req, sampled at an edge in any state:
  - All 16 valid bits are cleared.
  - The FIFO is emptied.
  - Any update accepted at the same edge is discarded.
  - The state becomes FLUSH with cnt=0.
- FLUSH:
  - Outputs: btb_wen=1, btb_windex=cnt, btb_wdata=0, flush_busy=1.
  - cnt increments each cycle.
  - After the cycle with cnt=15, the state returns to IDLE.
  - The FIFO does not pop. New updates are accepted until the FIFO is full.
  - Valid bits are not modified except by flush_req.
  - flush_req during FLUSH restarts the sweep at cnt=0 and clears the FIFO again.
- pred_hit reads valid bits before the edge. A same-cycle update to fetch_index is not visible until the next cycle.
- Successive updates to the same index are applied in FIFO order; the last one wins.

## Timing

- Reset values: state IDLE, cnt=0, FIFO empty, valid=0. Outputs: btb_wen=0, btb_windex=0, btb_wdata=0, upd_ready=1, flush_busy=0, pred_hit=0.
- rst_n asserted mid-flush or mid-drain aborts immediately to the reset values.
- Update latency:
  - An update accepted at the edge ending cycle N with the FIFO empty is issued in cycle N+1.
  - The BTB and valid bit commit at the edge ending N+1.
  - pred_hit reflects it from cycle N+2.
- Throughput: one update per cycle sustained in IDLE.
- Flush: flush_req sampled at edge E. The sweep runs for cycles E+1..E+16. IDLE resumes and the FIFO head is issued in cycle E+17.
- FIFO pointers wrap modulo DEPTH. The count is tracked with log2(DEPTH)+1 bits.

## Test plan

- Reset then idle: hold rst_n=0 for 2 cycles, release → all outputs at reset values, pred_hit=0 for every fetch_index 0..15.
- Single install: push {idx=5, target=0x1234, taken=1} at edge N.
  - Cycle N+1: btb_wen=1, btb_windex=5, btb_wdata=0x1234.
  - fetch_index=5 gives pred_hit=0 in N+1 and 1 in N+2.
- Invalidate: after the install above, push {idx=5, taken=0} → btb_wen=0 on issue; pred_hit for index 5 drops one cycle later.
- Flush with backpressure:
  - Install indices 1 and 2, then pulse flush_req. pred_hit=0 everywhere from the next cycle.
  - Sixteen writes of 0 follow with btb_windex 0..15 and flush_busy=1.
  - Push 3 updates during the sweep: 2 are accepted, then upd_ready=0.
  - After the sweep, the 2 buffered updates issue on consecutive cycles.
- Flush collisions:
  - flush_req coincident with an accepted update → that update never issues.
  - flush_req at cnt=9 → the sweep restarts at 0 and 16 more writes follow.
- Reset mid-sweep: drop rst_n at cnt=7 → btb_wen=0 and flush_busy=0 immediately. After release the block stays in IDLE with the FIFO empty.

Source files
------------

// File: rtl/btb_update_ctrl.sv
// BTB update sequencer: buffers decode-stage target updates in a small FIFO,
// drains them one per cycle into the BTB, tracks per-entry valid bits and runs a zeroing sweep on flush.
module btb_update_ctrl #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  fetch_index,
  output logic        pred_hit,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [3:0]  upd_index,
  input  logic [15:0] upd_target,
  input  logic        upd_taken,
  input  logic        flush_req,
  output logic        flush_busy,
  output logic        btb_wen,
  output logic [3:0]  btb_windex,
  output logic [15:0] btb_wdata
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, FLUSH} state_t;

  typedef struct packed {
    logic [3:0]  index;
    logic [15:0] target;
    logic        taken;
  } upd_t;

  state_t          state;
  logic [3:0]      cnt;
  upd_t            fifo [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [AW:0]     count;
  logic [15:0]     valid;

  upd_t head;
  logic fifo_empty, push, pop;

  assign head       = fifo[rd_ptr];
  assign fifo_empty = (count == '0);
  assign upd_ready  = (count != FULL_COUNT);
  assign push       = upd_valid && upd_ready;
  assign pop        = (state == IDLE) && !fifo_empty;
  assign pred_hit   = valid[fetch_index];
  assign flush_busy = (state == FLUSH);

  // Storage needs no reset: the head is only consumed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= '{index: upd_index, target: upd_target, taken: upd_taken};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else if (flush_req) begin
      // Flush wins over everything, including an update accepted at this edge.
      state  <= FLUSH;
      cnt    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            valid[head.index] <= head.taken;
            rd_ptr            <= rd_ptr + 1'b1;
          end
        end
        FLUSH: begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'hF) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (push) wr_ptr <= wr_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_comb begin
    btb_wen    = 1'b0;
    btb_windex = '0;
    btb_wdata  = '0;
    if (state == FLUSH) begin
      btb_wen    = 1'b1;
      btb_windex = cnt;
    end else if (!fifo_empty) begin
      btb_wen    = head.taken;
      btb_windex = head.index;
      btb_wdata  = head.target;
    end
  end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Self-checking bench for btb_update_ctrl: directed scenarios plus random traffic,
// compared cycle by cycle against a queue-based reference model.
module tb_btb_update_ctrl;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  fetch_index;
  logic        pred_hit;
  logic        upd_valid;
  logic        upd_ready;
  logic [3:0]  upd_index;
  logic [15:0] upd_target;
  logic        upd_taken;
  logic        flush_req;
  logic        flush_busy;
  logic        btb_wen;
  logic [3:0]  btb_windex;
  logic [15:0] btb_wdata;

  btb_update_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_index(fetch_index), .pred_hit(pred_hit),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_index(upd_index),
    .upd_target(upd_target), .upd_taken(upd_taken), .flush_req(flush_req),
    .flush_busy(flush_busy), .btb_wen(btb_wen), .btb_windex(btb_windex),
    .btb_wdata(btb_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  idx;
    logic [15:0] tgt;
    logic        tk;
  } mupd_t;

  mupd_t mq[$];
  bit    mv[16];
  int    m_sweep;   // sweep cycles still to run; current cnt is 16 - m_sweep
  int    checks   = 0;
  int    failures = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    foreach (mv[i]) mv[i] = 1'b0;
    m_sweep = 0;
  endtask

  task automatic check_outputs();
    logic        ew;
    logic [3:0]  ei;
    logic [15:0] ed;
    ew = 1'b0; ei = 4'd0; ed = 16'd0;
    if (m_sweep > 0) begin
      ew = 1'b1; ei = 4'(16 - m_sweep);
    end else if (mq.size() > 0) begin
      ew = mq[0].tk; ei = mq[0].idx; ed = mq[0].tgt;
    end
    chk("upd_ready",  16'(upd_ready),  16'(mq.size() < DEPTH));
    chk("flush_busy", 16'(flush_busy), 16'(m_sweep > 0));
    chk("pred_hit",   16'(pred_hit),   16'(mv[fetch_index]));
    chk("btb_wen",    16'(btb_wen),    16'(ew));
    if (ew || mq.size() == 0) begin
      chk("btb_windex", 16'(btb_windex), 16'(ei));
      chk("btb_wdata",  btb_wdata,       ed);
    end
  endtask

  // One clock cycle: drive inputs, check DUT against the model, then advance the model at the edge.
  task automatic step(input logic v, input logic [3:0] i, input logic [15:0] t,
                      input logic tk, input logic f, input logic [3:0] fi);
    bit    acc;
    mupd_t h;
    upd_valid = v; upd_index = i; upd_target = t; upd_taken = tk;
    flush_req = f; fetch_index = fi;
    #1;
    check_outputs();
    acc = v && (mq.size() < DEPTH);
    @(posedge clk);
    if (f) begin
      mq.delete();
      foreach (mv[k]) mv[k] = 1'b0;
      m_sweep = 16;
    end else begin
      if (m_sweep > 0) m_sweep--;
      else if (mq.size() > 0) begin
        h = mq.pop_front();
        mv[h.idx] = h.tk;
      end
      if (acc) mq.push_back('{i, t, tk});
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 4'd0, 16'd0, 1'b0, 1'b0, 4'($urandom));
  endtask

  task automatic rstep();
    step(1'($urandom), 4'($urandom), 16'($urandom), 1'($urandom),
         ($urandom % 40) == 0, 4'($urandom));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; upd_valid = 1'b0; upd_index = '0; upd_target = '0;
    upd_taken = 1'b0; flush_req = 1'b0; fetch_index = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_wen",    16'(btb_wen),    16'd0);
    chk("rst_windex", 16'(btb_windex), 16'd0);
    chk("rst_wdata",  btb_wdata,       16'd0);
    chk("rst_ready",  16'(upd_ready),  16'd1);
    chk("rst_busy",   16'(flush_busy), 16'd0);
    for (int i = 0; i < 16; i++) begin
      fetch_index = 4'(i);
      #1 chk("rst_pred_hit", 16'(pred_hit), 16'd0);
    end
    @(negedge clk);

    // Single install of index 5, then invalidate it.
    step(1'b1, 4'd5, 16'h1234, 1'b1, 1'b0, 4'd5);
    step(1'b0, 4'd0, 16'd0,    1'b0, 1'b0, 4'd5);
    step(1'b0, 4'd0, 16'd0,    1'b0, 1'b0, 4'd5);
    step(1'b1, 4'd5, 16'h0,    1'b0, 1'b0, 4'd5);
    step(1'b0, 4'd0, 16'd0,    1'b0, 1'b0, 4'd5);
    step(1'b0, 4'd0, 16'd0,    1'b0, 1'b0, 4'd5);

    // Install 1 and 2, flush, then push 3 updates during the sweep.
    step(1'b1, 4'd1, 16'hAAAA, 1'b1, 1'b0, 4'd1);
    step(1'b1, 4'd2, 16'hBBBB, 1'b1, 1'b0, 4'd2);
    idle(2);
    step(1'b0, 4'd0, 16'd0, 1'b0, 1'b1, 4'd1);
    for (int k = 0; k < 16; k++)
      step(k < 3, 4'(8 + k), 16'(16'hC000 + k), 1'b1, 1'b0, 4'(k));
    chk("sweep_backpressure_len", 16'(mq.size()), 16'(DEPTH));
    idle(4);

    // Flush coincident with an accepted update: that update is dropped.
    step(1'b1, 4'd7, 16'h7777, 1'b1, 1'b1, 4'd7);
    idle(20);

    // Flush again at cnt=9 restarts the sweep.
    step(1'b0, 4'd0, 16'd0, 1'b0, 1'b1, 4'd0);
    for (int k = 0; k < 32 && m_sweep != 7; k++) idle(1);
    step(1'b1, 4'd3, 16'h3333, 1'b1, 1'b1, 4'd3);
    idle(18);

    // Reset in the middle of a sweep at cnt=7.
    step(1'b1, 4'd4, 16'h4444, 1'b1, 1'b1, 4'd4);
    for (int k = 0; k < 32 && m_sweep != 9; k++) idle(1);
    rst_n = 1'b0;
    #1;
    chk("midrst_wen",    16'(btb_wen),    16'd0);
    chk("midrst_busy",   16'(flush_busy), 16'd0);
    chk("midrst_windex", 16'(btb_windex), 16'd0);
    chk("midrst_ready",  16'(upd_ready),  16'd1);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);

    // Random traffic with occasional flushes.
    for (int k = 0; k < 600; k++) rstep();
    idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
